// File: rtl/link_rx.sv
// Receive side of the two-board Connect-4 link: conditions the peer token and
// shared direction lines, then decodes the opponent's cursor moves and drop.
module link_rx #(
  parameter int NCOLS         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_peer_send,
  input  logic                       i_local_send,
  input  logic                       i_left_data,
  input  logic                       i_right_data,
  output logic                       o_opp_turn,
  output logic                       o_opp_left,
  output logic                       o_opp_right,
  output logic                       o_opp_put,
  output logic [$clog2(NCOLS)-1:0]   o_opp_col,
  output logic                       o_link_err
);

  localparam int COLW   = $clog2(NCOLS);
  localparam int CNTW   = $clog2(STABLE_CYCLES);
  localparam int NLINES = 3;
  localparam logic [COLW-1:0] CENTER  = COLW'((NCOLS - 1) / 2);
  localparam logic [COLW-1:0] COL_MAX = COLW'(NCOLS - 1);
  localparam logic [CNTW-1:0] CNT_END = CNTW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEER,
    S_DROP
  } state_t;

  // Line index 0 = token, 1 = left, 2 = right.
  logic [NLINES-1:0] w_raw;
  logic [NLINES-1:0] w_filt;
  logic [NLINES-1:0] w_prev;

  assign w_raw = {i_right_data, i_left_data, i_peer_send};

  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNTW-1:0]        r_cnt;
      logic                   r_filt;
      logic                   r_prev;
      logic                   w_sync;

      assign w_sync = r_sync[SYNC_STAGES-1];

      // A new level is accepted only after STABLE_CYCLES consecutive samples.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_filt <= 1'b0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
          r_prev <= r_filt;
          if (w_sync == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_END) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_filt[gi] = r_filt;
      assign w_prev[gi] = r_prev;
    end
  endgenerate

  logic w_send_rise;
  logic w_send_fall;
  logic w_left_rise;
  logic w_right_rise;
  logic w_collide;

  assign w_send_rise  =  w_filt[0] & ~w_prev[0];
  assign w_send_fall  = ~w_filt[0] &  w_prev[0];
  assign w_left_rise  =  w_filt[1] & ~w_prev[1];
  assign w_right_rise =  w_filt[2] & ~w_prev[2];
  assign w_collide    =  i_local_send & w_filt[0];

  state_t            r_state;
  state_t            w_state_next;
  logic [COLW-1:0]   r_col;
  logic [COLW-1:0]   w_col_next;
  logic              r_left, r_right, r_put, r_turn, r_err;
  logic              w_left_next, w_right_next, w_put_next, w_turn_next, w_err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_col   <= CENTER;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_put   <= 1'b0;
      r_turn  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_left  <= w_left_next;
      r_right <= w_right_next;
      r_put   <= w_put_next;
      r_turn  <= w_turn_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_left_next  = 1'b0;
    w_right_next = 1'b0;
    w_put_next   = 1'b0;
    w_err_next   = r_err | w_collide;

    // Both sides claiming the lines aborts the turn with no drop.
    if (w_collide) begin
      w_state_next = S_IDLE;
      w_col_next   = CENTER;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_send_rise && !i_local_send) begin
            w_state_next = S_PEER;
          end
        end
        S_PEER: begin
          if (w_send_fall) begin
            w_state_next = S_DROP;
            w_put_next   = 1'b1;
          end else if (w_left_rise && !w_right_rise) begin
            if (r_col != '0) begin
              w_col_next  = r_col - 1'b1;
              w_left_next = 1'b1;
            end
          end else if (w_right_rise && !w_left_rise) begin
            if (r_col < COL_MAX) begin
              w_col_next   = r_col + 1'b1;
              w_right_next = 1'b1;
            end
          end
        end
        S_DROP: begin
          w_state_next = S_IDLE;
          w_col_next   = CENTER;
        end
        default: begin
          w_state_next = S_IDLE;
          w_col_next   = CENTER;
        end
      endcase
    end

    w_turn_next = (w_state_next == S_PEER) || (w_state_next == S_DROP);
  end

  assign o_opp_turn  = r_turn;
  assign o_opp_left  = r_left;
  assign o_opp_right = r_right;
  assign o_opp_put   = r_put;
  assign o_opp_col   = r_col;
  assign o_link_err  = r_err;

endmodule

// File: tb/tb_link_rx.sv
// Directed bench for link_rx: expected pulses are queued as stimulus is driven
// and matched against every pulse the receiver emits.
module tb_link_rx;

  localparam int NCOLS = 7;
  localparam int K_LEFT = 1, K_RIGHT = 2, K_PUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_peer_send = 1'b0;
  logic       i_local_send = 1'b0;
  logic       i_left_data = 1'b0;
  logic       i_right_data = 1'b0;
  logic       o_opp_turn, o_opp_left, o_opp_right, o_opp_put, o_link_err;
  logic [2:0] o_opp_col;

  typedef struct {
    int kind;
    int col;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  checks = 0;
  int  failures = 0;
  int  m_col = 3;
  int  mon_n, mon_kind;

  always #5 clk = ~clk;

  link_rx #(.NCOLS(7), .SYNC_STAGES(2), .STABLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_peer_send(i_peer_send), .i_local_send(i_local_send),
    .i_left_data(i_left_data), .i_right_data(i_right_data),
    .o_opp_turn(o_opp_turn), .o_opp_left(o_opp_left), .o_opp_right(o_opp_right),
    .o_opp_put(o_opp_put), .o_opp_col(o_opp_col), .o_link_err(o_link_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line(input int which, input int hi, input int lo);
    if (which == K_LEFT) i_left_data = 1'b1; else i_right_data = 1'b1;
    tick(hi);
    if (which == K_LEFT) i_left_data = 1'b0; else i_right_data = 1'b0;
    tick(lo);
  endtask

  task automatic move_right();
    if (m_col < NCOLS - 1) begin
      m_col++;
      exp_q.push_back('{K_RIGHT, m_col});
    end
    pulse_line(K_RIGHT, 12, 12);
  endtask

  task automatic move_left();
    if (m_col > 0) begin
      m_col--;
      exp_q.push_back('{K_LEFT, m_col});
    end
    pulse_line(K_LEFT, 12, 12);
  endtask

  task automatic start_turn(input string tag);
    int k;
    k = 0;
    i_peer_send = 1'b1;
    while (!o_opp_turn && k < 30) begin
      tick(1);
      k++;
    end
    check(tag, 32'(k), 32'd11);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, 32'(o_opp_col), 32'd3);
    check({tag, "_turn"}, 32'(o_opp_turn), 32'd0);
    check({tag, "_pulses"}, 32'({o_opp_left, o_opp_right, o_opp_put}), 32'd0);
    check({tag, "_err"}, 32'(o_link_err), 32'd0);
  endtask

  // Pulse monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      mon_n = int'(o_opp_left) + int'(o_opp_right) + int'(o_opp_put);
      if (mon_n != 0) begin
        check("one_pulse_at_a_time", 32'(mon_n), 32'd1);
        mon_kind = o_opp_put ? K_PUT : (o_opp_right ? K_RIGHT : K_LEFT);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_kind", 32'(mon_kind), 32'd0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("pulse_kind", 32'(mon_kind), 32'(mon_ev.kind));
          check("pulse_col", 32'(o_opp_col), 32'(mon_ev.col));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    tick(3);
    check_reset_outputs("por");
    rst = 1'b1;
    tick(20);
    check_reset_outputs("por_release");

    // Basic turn: right, right, left, then drop at column 4
    start_turn("basic_turn_latency");
    move_right();
    move_right();
    move_left();
    check("basic_col_before_drop", 32'(o_opp_col), 32'd4);
    exp_q.push_back('{K_PUT, m_col});
    i_peer_send = 1'b0;
    tick(11);
    check("basic_col_during_put", 32'(o_opp_col), 32'd4);
    tick(1);
    m_col = 3;
    check("basic_col_after_put", 32'(o_opp_col), 32'd3);
    check("basic_turn_after_put", 32'(o_opp_turn), 32'd0);
    tick(4);
    check("basic_queue_drained", 32'(exp_q.size()), 32'd0);

    // Saturation at both ends
    start_turn("sat_turn_latency");
    repeat (5) move_right();
    check("sat_col_max", 32'(o_opp_col), 32'd6);
    repeat (8) move_left();
    check("sat_col_min", 32'(o_opp_col), 32'd0);
    check("sat_queue_drained", 32'(exp_q.size()), 32'd0);

    // Glitch rejection: short right pulse and short token dip
    pulse_line(K_RIGHT, 5, 20);
    i_peer_send = 1'b0;
    tick(3);
    i_peer_send = 1'b1;
    tick(20);
    check("glitch_col", 32'(o_opp_col), 32'd0);
    check("glitch_turn", 32'(o_opp_turn), 32'd1);

    // Asynchronous reset mid-turn at column 5
    repeat (5) move_right();
    check("midturn_col", 32'(o_opp_col), 32'd5);
    i_peer_send = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_col = 3;
    tick(3);
    rst = 1'b1;
    tick(20);
    check_reset_outputs("reset_release");

    // Direction lines toggled while idle
    repeat (2) begin
      pulse_line(K_LEFT, 12, 12);
      pulse_line(K_RIGHT, 12, 12);
    end
    check("idle_turn", 32'(o_opp_turn), 32'd0);
    check("idle_col", 32'(o_opp_col), 32'd3);

    // Token drop coincident with a right edge
    start_turn("simul_turn_latency");
    move_right();
    exp_q.push_back('{K_PUT, m_col});
    i_peer_send = 1'b0;
    i_right_data = 1'b1;
    tick(14);
    i_right_data = 1'b0;
    tick(12);
    m_col = 3;
    check("simul_col_after_put", 32'(o_opp_col), 32'd3);
    check("simul_queue_drained", 32'(exp_q.size()), 32'd0);

    // Collision: both sides claim the lines
    i_local_send = 1'b1;
    i_peer_send = 1'b1;
    tick(10);
    check("coll_err_edge10", 32'(o_link_err), 32'd0);
    tick(1);
    check("coll_err_edge11", 32'(o_link_err), 32'd1);
    check("coll_turn", 32'(o_opp_turn), 32'd0);
    i_peer_send = 1'b0;
    tick(15);
    check("coll_err_sticky", 32'(o_link_err), 32'd1);
    check("coll_col", 32'(o_opp_col), 32'd3);
    i_local_send = 1'b0;
    tick(15);
    check("coll_err_still_set", 32'(o_link_err), 32'd1);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
